// File: rtl/i281_dump_pkg.sv
// i281_dump_pkg: shared FSM state encoding and UART 8N1 framing constants for the data-memory dump
package i281_dump_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, FINISH} state_t;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT = 1'b1;
   localparam int DATA_BITS = 8;
endpackage

// File: rtl/i281_uart_tx_byte.sv
// i281_uart_tx_byte: emits one 8N1 frame per load pulse; a load during the last stop-bit cycle chains frames with no gap
module i281_uart_tx_byte
   import i281_dump_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] data,
   output logic       tx,
   output logic       frame_done
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   state_t state, state_nx;
   logic [CW-1:0] baud, baud_nx;
   logic [2:0] bit_cnt, bit_nx;
   logic [7:0] shreg, sh_nx;
   logic wrap;
   assign wrap = baud == CW'(CLKS_PER_BIT - 1);
   assign frame_done = state == STOP && wrap;
   assign tx = state == START ? START_BIT : state == DATA ? shreg[0] : STOP_BIT;
   // frame state, baud/bit counters and shift register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         baud <= '0;
         bit_cnt <= '0;
         shreg <= '0;
      end else begin
         state <= state_nx;
         baud <= baud_nx;
         bit_cnt <= bit_nx;
         shreg <= sh_nx;
      end
   end
   // bit sequencing: every phase advances on a baud wrap; load has priority to start a new frame
   always_comb begin
      state_nx = state;
      baud_nx = (wrap || state == IDLE) ? '0 : baud + 1'b1;
      bit_nx = bit_cnt;
      sh_nx = shreg;
      case (state)
         START: if (wrap) state_nx = DATA;
         DATA: if (wrap) begin
            sh_nx = shreg >> 1;
            bit_nx = bit_cnt + 1'b1;
            if (bit_cnt == 3'(DATA_BITS - 1)) state_nx = STOP;
         end
         STOP: if (wrap) state_nx = IDLE;
         default: ;
      endcase
      if (load) begin
         state_nx = START;
         baud_nx = '0;
         bit_nx = '0;
         sh_nx = data;
      end
   end
endmodule

// File: rtl/i281_datamem_uart_dump.sv
// i281_datamem_uart_dump: snapshots the i281 data memory and streams it as 8N1 bytes; I281_DUMP_CHECKSUM_EN appends a mod-256 sum byte
module i281_datamem_uart_dump
   import i281_dump_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int NUM_BYTES = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] datamem_bus,
   output logic         tx,
   output logic         busy,
   output logic         done,
   output logic [3:0]   byte_idx
);
`ifdef I281_DUMP_CHECKSUM_EN
   localparam logic [4:0] LAST = 5'(NUM_BYTES);
`else
   localparam logic [4:0] LAST = 5'(NUM_BYTES - 1);
`endif
   state_t state, state_nx;
   logic [4:0] idx, idx_nx;
   logic [15:0][7:0] snap, snap_nx;
   logic load, frame_done;
   logic [7:0] load_byte;
   i281_uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_frame (
      .clock(clock),
      .reset(reset),
      .load(load),
      .data(load_byte),
      .tx(tx),
      .frame_done(frame_done)
   );
`ifdef I281_DUMP_CHECKSUM_EN
   logic [7:0] csum;
   // modulo-256 sum of the snapshot, stable for the whole dump
   always_comb begin
      csum = '0;
      for (int i = 0; i < NUM_BYTES; i++) csum = csum + snap[i];
   end
`endif
   assign busy = state == DATA;
   assign done = state == FINISH;
   assign byte_idx = idx[3:0];
   // top-level sequencing state, byte index and snapshot
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         idx <= '0;
         snap <= '0;
      end else begin
         state <= state_nx;
         idx <= idx_nx;
         snap <= snap_nx;
      end
   end
   // DATA spans the whole byte stream; the per-bit START/DATA/STOP phases live in the frame sub-module
   always_comb begin
      state_nx = state;
      idx_nx = idx;
      snap_nx = snap;
      load = 1'b0;
      case (state)
         IDLE: if (start) begin
            state_nx = DATA;
            idx_nx = '0;
            snap_nx = datamem_bus;
            load = 1'b1;
         end
         DATA: if (frame_done) begin
            if (idx == LAST) begin
               state_nx = FINISH;
               idx_nx = '0;
            end else begin
               idx_nx = idx + 1'b1;
               load = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      load_byte = snap_nx[idx_nx[3:0]];
`ifdef I281_DUMP_CHECKSUM_EN
      if (idx_nx == 5'(NUM_BYTES)) load_byte = csum;
`endif
   end
endmodule

// File: tb/tb_i281_datamem_uart_dump.sv
// tb_i281_datamem_uart_dump: scoreboard bench decoding the tx stream of the data-memory dumper
module tb_i281_datamem_uart_dump;
   localparam int C = 4;
   localparam int N = 16;
`ifdef I281_DUMP_CHECKSUM_EN
   localparam int NF = N + 1;
`else
   localparam int NF = N;
`endif
   localparam int DUMP_CYC = NF * 10 * C + 1;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic [127:0] datamem_bus = '0;
   logic tx, busy, done;
   logic [3:0] byte_idx;
   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   logic rx_on = 1'b0;
   int rx_cnt = 0;
   logic [9:0] rx_sh = '0;
   logic [9:0] rx_q[$];
   logic [7:0] exp_q[$];

   i281_datamem_uart_dump #(.CLKS_PER_BIT(C), .NUM_BYTES(N)) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .datamem_bus(datamem_bus),
      .tx(tx),
      .busy(busy),
      .done(done),
      .byte_idx(byte_idx)
   );

   always #5 clock = ~clock;

   // serial receiver: mid-bit sampling on falling edges, frames pushed as {stop, data, start}
   always @(negedge clock) begin
      if (done) done_cnt <= done_cnt + 1;
      if (!reset) rx_on <= 1'b0;
      else if (rx_on) begin
         if (rx_cnt % C == C / 2) rx_sh <= {tx, rx_sh[9:1]};
         if (rx_cnt == 9 * C + C / 2) rx_q.push_back({tx, rx_sh[9:1]});
         rx_on <= rx_cnt != 9 * C + C / 2;
         rx_cnt <= rx_cnt + 1;
      end else if (!tx) begin
         rx_on <= 1'b1;
         rx_cnt <= 1;
      end
   end

   task automatic set_bus(input logic [7:0] base, input logic [7:0] step);
      for (int i = 0; i < 16; i++) datamem_bus[8*i +: 8] = 8'(base + step * 8'(i));
   endtask

   task automatic push_exp();
      logic [7:0] s = '0;
      for (int i = 0; i < N; i++) begin
         exp_q.push_back(datamem_bus[8*i +: 8]);
         s = s + datamem_bus[8*i +: 8];
      end
`ifdef I281_DUMP_CHECKSUM_EN
      exp_q.push_back(s);
`endif
   endtask

   task automatic do_start();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(output int at, output logic b_at, output logic b_pre, output logic [3:0] idx_mid);
      logic pb = 1'b1;
      at = -1;
      b_at = 1'bx;
      b_pre = 1'bx;
      idx_mid = 'x;
      for (int n = 1; n <= 1000; n++) begin
         @(negedge clock);
         if (n == 210) idx_mid = byte_idx;
         if (done) begin
            at = n;
            b_at = busy;
            b_pre = pb;
            break;
         end
         pb = busy;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      checks++;
      if ({tx, busy, done, byte_idx} !== 7'b1000000) begin
         failures++;
         $display("FAIL reset_hold got tx=%b busy=%b done=%b idx=%0d exp tx=1 busy=0 done=0 idx=0", tx, busy, done, byte_idx);
      end
      reset = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clock);
         checks++;
         if ({tx, busy, done, byte_idx} !== 7'b1000000) begin
            failures++;
            $display("FAIL idle_quiet cyc=%0d got tx=%b busy=%b done=%b idx=%0d exp 1/0/0/0", n, tx, busy, done, byte_idx);
         end
      end
   endtask

   task automatic test_basic();
      int at;
      logic b_at, b_pre;
      logic [3:0] im;
      logic [9:0] f;
      logic [7:0] e;
      set_bus(8'h10, 8'h01);
      push_exp();
      rx_q.delete();
      do_start();
      checks++;
      if (tx !== 1'b0 || busy !== 1'b1 || byte_idx !== 4'd0) begin
         failures++;
         $display("FAIL basic_accept got tx=%b busy=%b idx=%0d exp tx=0 busy=1 idx=0", tx, busy, byte_idx);
      end
      wait_done(at, b_at, b_pre, im);
      checks++;
      if (at !== DUMP_CYC) begin
         failures++;
         $display("FAIL basic_done_cycle got=%0d exp=%0d", at, DUMP_CYC);
      end
      checks++;
      if (b_at !== 1'b0 || b_pre !== 1'b1) begin
         failures++;
         $display("FAIL basic_busy_fall got busy_at_done=%b busy_before=%b exp 0/1", b_at, b_pre);
      end
      checks++;
      if (im !== 4'd5) begin
         failures++;
         $display("FAIL basic_byte_idx got=%0d exp=5", im);
      end
      repeat (4) @(posedge clock);
      checks++;
      if (rx_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL basic_count got=%0d exp=%0d", rx_q.size(), exp_q.size());
      end
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
         f = rx_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (f !== {1'b1, e, 1'b0}) begin
            failures++;
            $display("FAIL basic_frame got=%h exp=%h", f, {1'b1, e, 1'b0});
         end
      end
      exp_q.delete();
   endtask

   task automatic test_snapshot();
      int at;
      logic b_at, b_pre;
      logic [3:0] im;
      logic [9:0] f;
      logic [7:0] e;
      set_bus(8'hAA, 8'h00);
      push_exp();
      rx_q.delete();
      do_start();
      @(negedge clock);
      set_bus(8'h55, 8'h00);
      wait_done(at, b_at, b_pre, im);
      checks++;
      if (at !== DUMP_CYC - 1) begin
         failures++;
         $display("FAIL snap_done_cycle got=%0d exp=%0d", at, DUMP_CYC - 1);
      end
      repeat (4) @(posedge clock);
      checks++;
      if (rx_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL snap_count got=%0d exp=%0d", rx_q.size(), exp_q.size());
      end
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
         f = rx_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (f !== {1'b1, e, 1'b0}) begin
            failures++;
            $display("FAIL snap_frame got=%h exp=%h", f, {1'b1, e, 1'b0});
         end
      end
      exp_q.delete();
   endtask

   task automatic test_start_busy();
      int at, d0;
      logic b_at, b_pre;
      logic [3:0] im;
      logic [9:0] f;
      logic [7:0] e;
      set_bus(8'($urandom), 8'($urandom_range(1, 255)));
      push_exp();
      rx_q.delete();
      do_start();
      d0 = done_cnt;
      repeat (99) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_done(at, b_at, b_pre, im);
      checks++;
      if (at !== DUMP_CYC - 100) begin
         failures++;
         $display("FAIL busy_done_cycle got=%0d exp=%0d", at, DUMP_CYC - 100);
      end
      repeat (60) @(posedge clock);
      checks++;
      if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL busy_single_dump got done_pulses=%0d busy=%b exp 1/0", done_cnt - d0, busy);
      end
      checks++;
      if (rx_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL busy_count got=%0d exp=%0d", rx_q.size(), exp_q.size());
      end
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
         f = rx_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (f !== {1'b1, e, 1'b0}) begin
            failures++;
            $display("FAIL busy_frame got=%h exp=%h", f, {1'b1, e, 1'b0});
         end
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int at;
      logic b_at, b_pre;
      logic [3:0] im;
      logic [9:0] f;
      logic [7:0] e;
      set_bus(8'h10, 8'h01);
      rx_q.delete();
      do_start();
      repeat (218) @(negedge clock);
      checks++;
      if (tx !== 1'b0 || byte_idx !== 4'd5) begin
         failures++;
         $display("FAIL mid_pre got tx=%b idx=%0d exp tx=0 idx=5", tx, byte_idx);
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if ({tx, busy, done, byte_idx} !== 7'b1000000) begin
         failures++;
         $display("FAIL mid_async got tx=%b busy=%b done=%b idx=%0d exp 1/0/0/0", tx, busy, done, byte_idx);
      end
      checks++;
      if (rx_q.size() != 5) begin
         failures++;
         $display("FAIL mid_partial got=%0d exp=5", rx_q.size());
      end
      repeat (2) @(negedge clock);
      reset = 1'b1;
      rx_q.delete();
      set_bus(8'h20, 8'h03);
      push_exp();
      do_start();
      checks++;
      if (byte_idx !== 4'd0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_restart got idx=%0d busy=%b exp 0/1", byte_idx, busy);
      end
      wait_done(at, b_at, b_pre, im);
      checks++;
      if (at !== DUMP_CYC) begin
         failures++;
         $display("FAIL mid_done_cycle got=%0d exp=%0d", at, DUMP_CYC);
      end
      repeat (4) @(posedge clock);
      checks++;
      if (rx_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL mid_count got=%0d exp=%0d", rx_q.size(), exp_q.size());
      end
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
         f = rx_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (f !== {1'b1, e, 1'b0}) begin
            failures++;
            $display("FAIL mid_frame got=%h exp=%h", f, {1'b1, e, 1'b0});
         end
      end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      int at;
      logic b_at, b_pre;
      logic [3:0] im;
      set_bus(8'h40, 8'h01);
      rx_q.delete();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      wait_done(at, b_at, b_pre, im);
      checks++;
      if (at !== DUMP_CYC) begin
         failures++;
         $display("FAIL b2b_first_done got=%0d exp=%0d", at, DUMP_CYC);
      end
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         failures++;
         $display("FAIL b2b_idle_cycle got busy=%b tx=%b exp 0/1", busy, tx);
      end
      @(negedge clock);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || tx !== 1'b0) begin
         failures++;
         $display("FAIL b2b_restart got busy=%b tx=%b exp 1/0", busy, tx);
      end
      wait_done(at, b_at, b_pre, im);
      checks++;
      if (at !== DUMP_CYC - 1) begin
         failures++;
         $display("FAIL b2b_second_done got=%0d exp=%0d", at, DUMP_CYC - 1);
      end
      repeat (4) @(posedge clock);
   endtask

`ifdef I281_DUMP_CHECKSUM_EN
   task automatic test_checksum();
      int at;
      logic b_at, b_pre;
      logic [3:0] im;
      set_bus(8'h01, 8'h01);
      rx_q.delete();
      do_start();
      wait_done(at, b_at, b_pre, im);
      checks++;
      if (at !== 681) begin
         failures++;
         $display("FAIL csum_done_cycle got=%0d exp=681", at);
      end
      repeat (4) @(posedge clock);
      checks++;
      if (rx_q.size() != 17 || rx_q[rx_q.size() - 1] !== {1'b1, 8'h88, 1'b0}) begin
         failures++;
         $display("FAIL csum_byte got count=%0d last=%h exp 17/%h", rx_q.size(), rx_q.size() > 0 ? rx_q[rx_q.size() - 1] : 10'h0, {1'b1, 8'h88, 1'b0});
      end
      rx_q.delete();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_snapshot();
      test_start_busy();
      test_reset_mid();
      test_back_to_back();
`ifdef I281_DUMP_CHECKSUM_EN
      test_checksum();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
